ps2_mouse_packet_tracker: RTL and testbench

Downstream consumer of the PS/2 byte receiver in the mouse path. Assembles the standard 3-byte PS/2 mouse stream packets from received bytes and decodes the button states and signed X/Y movement. Accumulates a clamped on-screen cursor position for the VGA/HEX display logic. Detects framing loss and recovers from it with a sync-bit check and an inter-byte timeout.

---
 rtl/ps2_mouse_packet_tracker.sv | 168 ++++++++++++++++
 tb/tb_ps2_mouse_packet_tracker.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_packet_tracker.sv
// PS/2 mouse stream packet assembler: frames 3-byte packets, decodes buttons/deltas,
// and keeps a clamped cursor position. Framing loss recovers via sync bit and inter-byte timeout.
module ps2_mouse_packet_tracker #(
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       iCLK_50,
    input  logic       iRST_n,
    input  logic [7:0] iBYTE,
    input  logic       iBYTE_VALID,
    input  logic       iCENTER,
    output logic       oLEFBUT,
    output logic       oRIGBUT,
    output logic       oMIDBUT,
    output logic [8:0] oDX,
    output logic [8:0] oDY,
    output logic       oX_OVF,
    output logic       oY_OVF,
    output logic       oPKT_VALID,
    output logic [9:0] oX_POS,
    output logic [9:0] oY_POS,
    output logic       oSYNC_ERR
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {B0, B1, B2} state_t;

    state_t        state_q, state_d;
    logic [7:0]    byte0_q, byte0_d, byte1_q, byte1_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    btn_q, btn_d;
    logic [8:0]    dx_q, dx_d, dy_q, dy_d;
    logic          xovf_q, xovf_d, yovf_q, yovf_d;
    logic          pkt_q, pkt_d, serr_q, serr_d;
    logic [9:0]    x_q, x_d, y_q, y_d;

    logic [8:0]         dx_w, dy_w;
    logic signed [11:0] x_sum, y_sum;
    logic [9:0]         x_clamp, y_clamp;
    logic               expired;

    assign dx_w = {byte0_q[4], byte1_q};
    assign dy_w = {byte0_q[5], iBYTE};

    // Screen Y grows downward, so positive (upward) dy is subtracted.
    assign x_sum = $signed({2'b00, x_q}) + $signed({{3{dx_w[8]}}, dx_w});
    assign y_sum = $signed({2'b00, y_q}) - $signed({{3{dy_w[8]}}, dy_w});

    always_comb begin
        x_clamp = x_sum[9:0];
        if (x_sum[11])                         x_clamp = '0;
        else if (x_sum > $signed(12'(X_MAX)))  x_clamp = 10'(X_MAX);
        y_clamp = y_sum[9:0];
        if (y_sum[11])                         y_clamp = '0;
        else if (y_sum > $signed(12'(Y_MAX)))  y_clamp = 10'(Y_MAX);
    end

    assign expired = (timer_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d = state_q;
        byte0_d = byte0_q;
        byte1_d = byte1_q;
        timer_d = timer_q;
        btn_d   = btn_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        xovf_d  = xovf_q;
        yovf_d  = yovf_q;
        pkt_d   = 1'b0;
        serr_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;

        case (state_q)
            B0: begin
                timer_d = '0;
                if (iBYTE_VALID) begin
                    if (iBYTE[3]) begin
                        byte0_d = iBYTE;
                        state_d = B1;
                    end else begin
                        serr_d = 1'b1;
                    end
                end
            end
            B1, B2: begin
                // A byte arriving in the expiry cycle takes priority over the timeout.
                if (iBYTE_VALID) begin
                    timer_d = '0;
                    if (state_q == B1) begin
                        byte1_d = iBYTE;
                        state_d = B2;
                    end else begin
                        state_d = B0;
                        pkt_d   = 1'b1;
                        btn_d   = byte0_q[2:0];
                        dx_d    = dx_w;
                        dy_d    = dy_w;
                        xovf_d  = byte0_q[6];
                        yovf_d  = byte0_q[7];
                        if (!byte0_q[6]) x_d = x_clamp;
                        if (!byte0_q[7]) y_d = y_clamp;
                    end
                end else if (expired) begin
                    timer_d = '0;
                    state_d = B0;
                    serr_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = B0;
        endcase

        if (iCENTER) begin
            x_d = 10'(X_INIT);
            y_d = 10'(Y_INIT);
        end
    end

    always_ff @(posedge iCLK_50) begin
        if (!iRST_n) begin
            state_q <= B0;
            byte0_q <= '0;
            byte1_q <= '0;
            timer_q <= '0;
            btn_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            xovf_q  <= 1'b0;
            yovf_q  <= 1'b0;
            pkt_q   <= 1'b0;
            serr_q  <= 1'b0;
            x_q     <= 10'(X_INIT);
            y_q     <= 10'(Y_INIT);
        end else begin
            state_q <= state_d;
            byte0_q <= byte0_d;
            byte1_q <= byte1_d;
            timer_q <= timer_d;
            btn_q   <= btn_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            xovf_q  <= xovf_d;
            yovf_q  <= yovf_d;
            pkt_q   <= pkt_d;
            serr_q  <= serr_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign oLEFBUT    = btn_q[0];
    assign oRIGBUT    = btn_q[1];
    assign oMIDBUT    = btn_q[2];
    assign oDX        = dx_q;
    assign oDY        = dy_q;
    assign oX_OVF     = xovf_q;
    assign oY_OVF     = yovf_q;
    assign oPKT_VALID = pkt_q;
    assign oSYNC_ERR  = serr_q;
    assign oX_POS     = x_q;
    assign oY_POS     = y_q;
endmodule

// File: tb/tb_ps2_mouse_packet_tracker.sv
// Directed bench for ps2_mouse_packet_tracker with a shortened timeout.
module tb_ps2_mouse_packet_tracker;
    localparam int T = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte_i;
    logic       valid;
    logic       center;
    logic       lef, rig, mid, xovf, yovf, pkt, serr;
    logic [8:0] dx, dy;
    logic [9:0] xpos, ypos;

    int checks = 0;
    int errors = 0;

    ps2_mouse_packet_tracker #(.TIMEOUT_CYC(T)) dut (
        .iCLK_50(clk), .iRST_n(rst_n), .iBYTE(byte_i), .iBYTE_VALID(valid),
        .iCENTER(center), .oLEFBUT(lef), .oRIGBUT(rig), .oMIDBUT(mid),
        .oDX(dx), .oDY(dy), .oX_OVF(xovf), .oY_OVF(yovf), .oPKT_VALID(pkt),
        .oX_POS(xpos), .oY_POS(ypos), .oSYNC_ERR(serr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_i = b;
        valid  = 1'b1;
        step();
        valid  = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic ctr);
        send_byte(b0);
        send_byte(b1);
        center = ctr;
        send_byte(b2);
        center = 1'b0;
    endtask

    initial begin
        int first;
        rst_n = 1'b0; byte_i = '0; valid = 1'b0; center = 1'b0;
        step(); step();
        rst_n = 1'b1;
        chk("rst_x", 32'(xpos), 320);
        chk("rst_y", 32'(ypos), 240);
        chk("rst_pkt", 32'(pkt), 0);
        chk("rst_serr", 32'(serr), 0);
        chk("rst_dx", 32'(dx), 0);
        chk("rst_btn", 32'({mid, rig, lef}), 0);

        // dx=+5, dy=-5 (byte0 bit5 set): cursor moves right and down
        send_pkt(8'h29, 8'h05, 8'hFB, 1'b0);
        chk("p1_pkt", 32'(pkt), 1);
        chk("p1_lef", 32'(lef), 1);
        chk("p1_dx", 32'(dx), 32'h005);
        chk("p1_dy", 32'(dy), 32'h1FB);
        chk("p1_x", 32'(xpos), 325);
        chk("p1_y", 32'(ypos), 245);
        step();
        chk("p1_pkt_drop", 32'(pkt), 0);
        chk("p1_hold_x", 32'(xpos), 325);

        center = 1'b1; step(); center = 1'b0;
        chk("ctr_x", 32'(xpos), 320);
        chk("ctr_y", 32'(ypos), 240);
        send_pkt(8'h08, 8'hFF, 8'hEE, 1'b0);
        chk("mv1_x", 32'(xpos), 575);
        chk("mv1_y", 32'(ypos), 2);
        send_pkt(8'h08, 8'h3C, 8'h00, 1'b0);
        chk("mv2_x", 32'(xpos), 635);
        send_pkt(8'h08, 8'h0A, 8'h0A, 1'b0);
        chk("clamp_x", 32'(xpos), 639);
        chk("clamp_y", 32'(ypos), 0);
        chk("clamp_lef", 32'(lef), 0);
        // dx=-255, dy=-255
        send_pkt(8'h38, 8'h01, 8'h01, 1'b0);
        chk("neg_dx", 32'(dx), 32'h101);
        chk("neg_x", 32'(xpos), 384);
        chk("neg_y", 32'(ypos), 255);

        send_byte(8'h00);
        chk("sync_serr", 32'(serr), 1);
        chk("sync_pkt", 32'(pkt), 0);
        step();
        chk("sync_serr_drop", 32'(serr), 0);
        send_pkt(8'h0A, 8'h00, 8'h00, 1'b0);
        chk("sync_rec_pkt", 32'(pkt), 1);
        chk("sync_rig", 32'(rig), 1);
        chk("sync_x", 32'(xpos), 384);
        chk("sync_y", 32'(ypos), 255);

        send_byte(8'h08);
        send_byte(8'h01);
        first = -1;
        for (int n = 1; n <= T + 5; n++) begin
            step();
            if (serr) begin first = n; break; end
        end
        chk("timeout_cycle", 32'(first), 32'(T));
        center = 1'b1; step(); center = 1'b0;
        send_pkt(8'h0C, 8'h02, 8'h03, 1'b0);
        chk("to_pkt", 32'(pkt), 1);
        chk("to_mid", 32'(mid), 1);
        chk("to_x", 32'(xpos), 322);
        chk("to_y", 32'(ypos), 237);

        // Byte arriving exactly at the expiry cycle must be accepted
        send_byte(8'h08);
        for (int n = 0; n < T - 1; n++) step();
        send_byte(8'h01);
        chk("win_serr", 32'(serr), 0);
        send_byte(8'h00);
        chk("win_pkt", 32'(pkt), 1);
        chk("win_x", 32'(xpos), 323);

        send_pkt(8'h48, 8'hFF, 8'h00, 1'b0);
        chk("ovf_flag", 32'(xovf), 1);
        chk("ovf_yflag", 32'(yovf), 0);
        chk("ovf_dx", 32'(dx), 32'h0FF);
        chk("ovf_x", 32'(xpos), 323);
        chk("ovf_y", 32'(ypos), 237);

        send_pkt(8'h08, 8'h10, 8'h00, 1'b1);
        chk("ctrpkt_pkt", 32'(pkt), 1);
        chk("ctrpkt_dx", 32'(dx), 32'h010);
        chk("ctrpkt_x", 32'(xpos), 320);
        chk("ctrpkt_y", 32'(ypos), 240);

        send_byte(8'h08);
        send_byte(8'h05);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("midrst_dx", 32'(dx), 0);
        send_pkt(8'h08, 8'h03, 8'h00, 1'b0);
        chk("midrst_pkt", 32'(pkt), 1);
        chk("midrst_x", 32'(xpos), 323);
        chk("midrst_y", 32'(ypos), 240);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
